// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: the 2-bit direction
// counter encoding and the per-entry bookkeeping state.
package bp_pkg;

    // Direction counter; bit 1 set means "predict taken"
    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } bp_ctr_e;

    // Counter value every entry returns to on reset
    localparam bp_ctr_e CTR_RESET = CTR_WEAK_NT;

    // Counter value given to a freshly allocated entry
    localparam bp_ctr_e CTR_ALLOC = CTR_WEAK_T;

    // Per-entry state whose width does not depend on the module parameters.
    // The tag and target widths follow DATA_WIDTH/ENTRIES, so those fields
    // live in parallel arrays inside branch_predictor, indexed the same way.
    typedef struct packed {
        logic    valid;
        bp_ctr_e ctr;
    } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state: moves one step toward strong-taken
// on a taken outcome and toward strong-not-taken otherwise, holding at
// either end.
module bp_sat_counter
    import bp_pkg::*;
(
    input  bp_ctr_e i_ctr,
    input  logic    i_taken,
    output bp_ctr_e o_ctr
);

    // Step the counter one state in the resolved direction, saturating
    always_comb begin
        o_ctr = i_ctr;
        case (i_ctr)
            CTR_STRONG_NT: o_ctr = i_taken ? CTR_WEAK_NT  : CTR_STRONG_NT;
            CTR_WEAK_NT:   o_ctr = i_taken ? CTR_WEAK_T   : CTR_STRONG_NT;
            CTR_WEAK_T:    o_ctr = i_taken ? CTR_STRONG_T : CTR_WEAK_NT;
            CTR_STRONG_T:  o_ctr = i_taken ? CTR_STRONG_T : CTR_WEAK_T;
            default:       o_ctr = CTR_RESET;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is combinational on PC; the execute stage trains the table on the
// clock edge where upd_valid is high. Reset (rst) is asynchronous, active-low.
// Optional feature: define BP_STATS_EN to add the 32-bit stat_branches and
// stat_mispredicts counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] PC,
    output logic                  predict_taken,
    output logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  upd_valid,
    input  logic [DATA_WIDTH-1:0] upd_PC,
    input  logic                  upd_taken,
    input  logic [DATA_WIDTH-1:0] upd_target,
    input  logic                  upd_mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    // Table kept as plain registers so the asynchronous reset clears it at once
    bp_entry_t               r_state  [ENTRIES];
    logic [TAG_W-1:0]        r_tag    [ENTRIES];
    logic [DATA_WIDTH-1:0]   r_target [ENTRIES];

    logic [IDX_W-1:0]        w_lkIdx;
    logic [TAG_W-1:0]        w_lkTag;
    logic                    w_lkHit;

    logic [IDX_W-1:0]        w_updIdx;
    logic [TAG_W-1:0]        w_updTag;
    logic                    w_updHit;
    bp_ctr_e                 w_nextCtr;

    // Instruction addresses are word aligned, so the low two bits never
    // take part in indexing or tagging
    logic                    w_unusedLowBits;
    assign w_unusedLowBits = ^{PC[1:0], upd_PC[1:0]};

    assign w_lkIdx  = PC[IDX_W+1:2];
    assign w_lkTag  = PC[DATA_WIDTH-1:IDX_W+2];
    assign w_lkHit  = r_state[w_lkIdx].valid && (r_tag[w_lkIdx] == w_lkTag);

    assign w_updIdx = upd_PC[IDX_W+1:2];
    assign w_updTag = upd_PC[DATA_WIDTH-1:IDX_W+2];
    assign w_updHit = r_state[w_updIdx].valid && (r_tag[w_updIdx] == w_updTag);

    // Lookup reads the registered table, so a same-cycle update to the same
    // index is only seen from the following cycle
    assign predict_taken = w_lkHit && r_state[w_lkIdx].ctr[1];
    assign branch_target = w_lkHit ? r_target[w_lkIdx] : '0;

    bp_sat_counter u_satCounter (
        .i_ctr   (r_state[w_updIdx].ctr),
        .i_taken (upd_taken),
        .o_ctr   (w_nextCtr)
    );

    // Train the table: update on hit, allocate on a taken miss, ignore a not-taken miss
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_state[i]  <= '{valid: 1'b0, ctr: CTR_RESET};
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (upd_valid) begin
            if (w_updHit) begin
                r_state[w_updIdx].ctr <= w_nextCtr;
                if (upd_taken) begin
                    r_target[w_updIdx] <= upd_target;
                end
            end else if (upd_taken) begin
                r_state[w_updIdx]  <= '{valid: 1'b1, ctr: CTR_ALLOC};
                r_tag[w_updIdx]    <= w_updTag;
                r_target[w_updIdx] <= upd_target;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] r_statBranches;
    logic [31:0] r_statMispredicts;

    // Count resolved branches and flagged mispredicts; both wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_statBranches    <= '0;
            r_statMispredicts <= '0;
        end else if (upd_valid) begin
            r_statBranches <= r_statBranches + 32'd1;
            if (upd_mispredict) begin
                r_statMispredicts <= r_statMispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_statBranches;
    assign stat_mispredicts = r_statMispredicts;
`else
    // The mispredict flag only feeds the statistics counters
    logic w_unusedMispredict;
    assign w_unusedMispredict = upd_mispredict;
`endif

endmodule
